// File: rtl/jt12_pkg.sv
// jt12_pkg: shared scheduler state encoding and write-queue entry layout
package jt12_pkg;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  localparam int WRQ_W    = 10;
  localparam int DIN_LSB  = 0;
  localparam int DIN_MSB  = 7;
  localparam int ADDR_LSB = 8;
  localparam int ADDR_MSB = 9;
endpackage

// File: rtl/jt12_wrfifo.sv
// jt12_wrfifo: synchronous FIFO holding pending register writes
module jt12_wrfifo #(
  parameter int DEPTH = 4,
  parameter int W = 10,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rd_ptr];
  // pointers wrap modulo DEPTH; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset: only entries behind count are ever read
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/jt12_wrsched.sv
// jt12_wrsched: buffers CPU register writes and replays them at the core's pace
module jt12_wrsched
  import jt12_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int BUSY_CYC = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic       ovf_clr,
  output logic       out_wr,
  output logic [1:0] out_addr,
  output logic [7:0] out_din,
  output logic       busy,
  output logic       full,
  output logic       ovf
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             act, act_q, strobe, pop, push, drop, empty;
  logic [WRQ_W-1:0] head;
  logic [CW-1:0]    count, count_nx;
  state_t           state, state_nx;
  logic [7:0]       cnt, cnt_nx;
  assign act      = ~cs_n & ~wr_n;
  assign strobe   = act & ~act_q;
  assign pop      = (state == IDLE) & cen & ~empty;
  assign push     = strobe & (~full | pop);
  assign drop     = strobe & full & ~pop;
  assign count_nx = count + CW'(push) - CW'(pop);
  jt12_wrfifo #(.DEPTH(DEPTH), .W(WRQ_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({addr, din}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // data-port issues hold off the queue for BUSY_CYC cen ticks
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == IDLE) begin
      if (pop & head[ADDR_LSB]) begin
        state_nx = HOLD;
        cnt_nx   = 8'(BUSY_CYC - 1);
      end
    end else if (cen) begin
      state_nx = cnt == 8'd0 ? IDLE : HOLD;
      cnt_nx   = cnt == 8'd0 ? cnt : cnt - 8'd1;
    end
  end
  // edge detect, FSM state, issue register and status flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act_q    <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      out_wr   <= 1'b0;
      out_addr <= '0;
      out_din  <= '0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      act_q  <= act;
      state  <= state_nx;
      cnt    <= cnt_nx;
      out_wr <= pop;
      if (pop) begin
        out_addr <= head[ADDR_MSB:ADDR_LSB];
        out_din  <= head[DIN_MSB:DIN_LSB];
      end
      busy <= (count_nx != '0) | (state_nx == HOLD);
      ovf  <= drop | (ovf & ~ovf_clr);
    end
endmodule

// File: tb/tb_jt12_wrsched.sv
// tb_jt12_wrsched: scoreboard bench for the register write scheduler
module tb_jt12_wrsched;
  logic       clk = 0, rst_n = 0, cen_man = 0, ovf_clr = 0;
  logic       cs_n = 1, wr_n = 1, cs1_n = 1, wr1_n = 1;
  logic [1:0] addr = 0, addr1 = 0, div = 0;
  logic [7:0] din = 0, din1 = 0;
  logic [1:0] mode = 0;
  logic       cen;
  logic       out_wr, busy, full, ovf, out_wr1, busy1, full1, ovf1;
  logic [1:0] out_addr, out_addr1;
  logic [7:0] out_din, out_din1;
  logic [9:0] q[$], q1[$], e0, e1;
  int         n_chk = 0, n_fail = 0, n_wr = 0, n_wr1 = 0, cyc = 0;
  int         t_prev = 0, t_last = 0, t1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) div <= div + 2'd1;
  assign cen = mode == 2'd3 ? cen_man : mode == 2'd2 ? 1'b1 : mode == 2'd1 ? div == 2'd0 : 1'b0;

  jt12_wrsched #(.DEPTH(4), .BUSY_CYC(32)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
    .ovf_clr(ovf_clr), .out_wr(out_wr), .out_addr(out_addr), .out_din(out_din),
    .busy(busy), .full(full), .ovf(ovf));

  jt12_wrsched #(.DEPTH(4), .BUSY_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cen(1'b1), .cs_n(cs1_n), .wr_n(wr1_n), .addr(addr1), .din(din1),
    .ovf_clr(1'b0), .out_wr(out_wr1), .out_addr(out_addr1), .out_din(out_din1),
    .busy(busy1), .full(full1), .ovf(ovf1));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, a, e, cyc);
    end
  endtask

  always @(negedge clk)
    if (out_wr) begin
      n_wr++;
      t_prev = t_last;
      t_last = cyc;
      if (q.size() == 0) chk("wr_unexpected", {out_addr, out_din}, 32'hFFFF);
      else begin
        e0 = q.pop_front();
        chk("wr_entry", {out_addr, out_din}, e0);
      end
    end

  always @(negedge clk)
    if (out_wr1) begin
      n_wr1++;
      t1.push_back(cyc);
      if (q1.size() == 0) chk("wr1_unexpected", {out_addr1, out_din1}, 32'hFFFF);
      else begin
        e1 = q1.pop_front();
        chk("wr1_entry", {out_addr1, out_din1}, e1);
      end
    end

  task automatic wr(input bit s, input logic [1:0] a, input logic [7:0] d, input int hold, input bit exp);
    @(negedge clk);
    if (s) begin
      cs1_n = 0; wr1_n = 0; addr1 = a; din1 = d;
      if (exp) q1.push_back({a, d});
    end else begin
      cs_n = 0; wr_n = 0; addr = a; din = d;
      if (exp) q.push_back({a, d});
    end
    repeat (hold) @(negedge clk);
    cs_n = 1; wr_n = 1; cs1_n = 1; wr1_n = 1;
  endtask

  task automatic wait_wr(input bit s, input int n, input int budget);
    for (int k = 0; k < budget && (s ? n_wr1 : n_wr) < n; k++) begin
      @(negedge clk);
      #1;
    end
    chk(s ? "wr1_count" : "wr_count", s ? n_wr1 : n_wr, n);
  endtask

  task automatic tick();
    @(negedge clk);
    cen_man = 1;
    @(negedge clk);
    cen_man = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ticks;
    bit stay;
    repeat (3) @(negedge clk);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_din", out_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1;

    // address/data pair, cen every 4 clk
    mode = 0;
    wr(0, 2'd0, 8'h28, 1, 1);
    chk("pair_busy_rise", busy, 1);
    wr(0, 2'd1, 8'hF0, 1, 1);
    mode = 1;
    wait_wr(0, 2, 200);
    chk("pair_spacing", t_last - t_prev, 4);
    ticks = 0;
    stay = 1;
    while (ticks < 32) begin
      @(posedge clk);
      if (cen) ticks++;
      #1;
      if (ticks < 32 && !busy) stay = 0;
    end
    chk("pair_busy_held", stay, 1);
    chk("pair_busy_fall", busy, 0);

    // burst of 6 with cen low
    mode = 0;
    base = n_wr;
    for (int i = 0; i < 6; i++) begin
      wr(0, 2'd0, 8'h10 + 8'(i), 1, i < 4);
      if (i == 3) begin
        chk("burst_full", full, 1);
        chk("burst_no_ovf", ovf, 0);
      end
    end
    chk("burst_ovf", ovf, 1);
    chk("burst_busy", busy, 1);
    mode = 2;
    wait_wr(0, base + 4, 100);
    repeat (10) @(negedge clk);
    chk("burst_exact4", n_wr, base + 4);
    chk("burst_q_empty", q.size(), 0);
    chk("burst_ovf_sticky", ovf, 1);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    chk("ovf_clr", ovf, 0);

    // long strobe
    mode = 1;
    base = n_wr;
    wr(0, 2'd2, 8'h5A, 20, 1);
    wait_wr(0, base + 1, 100);
    repeat (30) @(negedge clk);
    chk("long_strobe_once", n_wr, base + 1);

    // push and pop on the same edge while full
    mode = 3;
    base = n_wr;
    for (int i = 0; i < 4; i++) wr(0, 2'd0, 8'h40 + 8'(i), 1, 1);
    chk("pp_full", full, 1);
    @(negedge clk);
    cs_n = 0; wr_n = 0; addr = 2'd2; din = 8'h44; cen_man = 1;
    q.push_back({2'd2, 8'h44});
    @(negedge clk);
    cs_n = 1; wr_n = 1; cen_man = 0;
    chk("pp_no_ovf", ovf, 0);
    chk("pp_still_full", full, 1);
    mode = 2;
    wait_wr(0, base + 5, 100);
    chk("pp_q_empty", q.size(), 0);
    chk("pp_ovf_final", ovf, 0);

    // reset mid-HOLD with 2 entries queued
    mode = 3;
    repeat (5) @(negedge clk);
    base = n_wr;
    wr(0, 2'd1, 8'h11, 1, 1);
    wr(0, 2'd0, 8'h22, 1, 0);
    wr(0, 2'd2, 8'h33, 1, 0);
    tick();
    repeat (21) tick();
    chk("hold_issued", n_wr, base + 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_wr", out_wr, 0);
    chk("mid_rst_out_addr", out_addr, 0);
    chk("mid_rst_out_din", out_din, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    mode = 2;
    base = n_wr;
    repeat (40) @(negedge clk);
    chk("post_rst_no_wr", n_wr, base);
    chk("post_rst_busy", busy, 0);

    // BUSY_CYC=1, cen tied high: data writes issue 2 clk apart
    wr(1, 2'd1, 8'h01, 1, 1);
    wr(1, 2'd3, 8'h02, 1, 1);
    wr(1, 2'd1, 8'h03, 1, 1);
    wait_wr(1, 3, 50);
    if (t1.size() == 3) begin
      chk("bc1_space_a", t1[1] - t1[0], 2);
      chk("bc1_space_b", t1[2] - t1[1], 2);
    end else chk("bc1_pulses", t1.size(), 3);
    repeat (5) @(negedge clk);
    chk("bc1_busy_fall", busy1, 0);
    chk("bc1_q_empty", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
